// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and the 12-bit coordinate type.
// The defaults describe 800x600@60 Hz with a 40 MHz pixel clock.
package vga_timing_pkg;

  localparam int COORD_W = 12;
  localparam int MAX_TOTAL = 1 << COORD_W;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COORD_W:0]   coord_ext_t;

  localparam int H_SYNC_DEF   = 128;
  localparam int H_BACK_DEF   = 88;
  localparam int H_ACTIVE_DEF = 800;
  localparam int H_FRONT_DEF  = 40;
  localparam int V_SYNC_DEF   = 4;
  localparam int V_BACK_DEF   = 23;
  localparam int V_ACTIVE_DEF = 600;
  localparam int V_FRONT_DEF  = 1;

  localparam int H_TOTAL_DEF     = H_SYNC_DEF + H_BACK_DEF + H_ACTIVE_DEF + H_FRONT_DEF;
  localparam int V_TOTAL_DEF     = V_SYNC_DEF + V_BACK_DEF + V_ACTIVE_DEF + V_FRONT_DEF;
  localparam int H_ACT_START_DEF = H_SYNC_DEF + H_BACK_DEF;
  localparam int H_ACT_END_DEF   = H_ACT_START_DEF + H_ACTIVE_DEF;
  localparam int V_ACT_START_DEF = V_SYNC_DEF + V_BACK_DEF;
  localparam int V_ACT_END_DEF   = V_ACT_START_DEF + V_ACTIVE_DEF;

  // Widening to 13 bits lets an active end of exactly 4096 compare correctly.
  function automatic coord_ext_t to_ext(input int value);
    logic [31:0] v;
    v = value;
    return v[COORD_W:0];
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: a wrapping counter decoded into sync, active window,
// first-position and active-relative coordinate (all combinational).
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int SYNC   = H_SYNC_DEF,
  parameter int BACK   = H_BACK_DEF,
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FRONT  = H_FRONT_DEF
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_en,
  output logic   o_wrap,
  output logic   o_first,
  output logic   o_sync,
  output logic   o_active,
  output coord_t o_coord
);

  localparam int TOTAL     = SYNC + BACK + ACTIVE + FRONT;
  localparam int ACT_START = SYNC + BACK;
  localparam int ACT_END   = ACT_START + ACTIVE;

  localparam coord_ext_t LAST_X      = to_ext(TOTAL - 1);
  localparam coord_ext_t SYNC_END_X  = to_ext(SYNC);
  localparam coord_ext_t ACT_START_X = to_ext(ACT_START);
  localparam coord_ext_t ACT_END_X   = to_ext(ACT_END);
  localparam coord_t     ACT_START_C = ACT_START_X[COORD_W-1:0];

  coord_t     r_cnt;
  coord_ext_t w_cnt_x;

  assign w_cnt_x  = {1'b0, r_cnt};
  assign o_wrap   = i_en && (w_cnt_x == LAST_X);
  assign o_first  = (r_cnt == '0);
  assign o_sync   = (w_cnt_x < SYNC_END_X);
  assign o_active = (w_cnt_x >= ACT_START_X) && (w_cnt_x < ACT_END_X);
  assign o_coord  = r_cnt - ACT_START_C;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_wrap ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vga_sync_gen_module.sv
// VGA sync/pixel-address generator: free-running H/V counters, registered syncs,
// Ready, column/row and a frame-start pulse. VGA_SYNC_PIPE_ALIGN_EN delays the syncs one more cycle.
module vga_sync_gen_module
  import vga_timing_pkg::*;
#(
  parameter int SYNC_UNUSED = 0,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BACK   = H_BACK_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FRONT  = H_FRONT_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BACK   = V_BACK_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FRONT  = V_FRONT_DEF,
  parameter bit H_POL    = 1'b1,
  parameter bit V_POL    = 1'b1
) (
  input  logic               vga_clk,
  input  logic               rst_n,
  output logic               HSYNC_Sig,
  output logic               VSYNC_Sig,
  output logic               Ready_Sig,
  output logic [COORD_W-1:0] Column_Addr_Sig,
  output logic [COORD_W-1:0] Row_Addr_Sig,
  output logic               Frame_Start_Sig
);

  logic   w_h_wrap, w_h_first, w_h_sync, w_h_active;
  logic   w_v_wrap, w_v_first, w_v_sync, w_v_active;
  coord_t w_h_coord, w_v_coord;
  logic   w_ready;

  logic   r_hsync_p1, r_vsync_p1;
  logic   r_ready_p1;
  coord_t r_col_p1, r_row_p1;
  logic   r_frame_start_p1;

  vga_axis_counter #(
    .SYNC   (H_SYNC),
    .BACK   (H_BACK),
    .ACTIVE (H_ACTIVE),
    .FRONT  (H_FRONT)
  ) u_h_cnt (
    .i_clk    (vga_clk),
    .i_rst_n  (rst_n),
    .i_en     (1'b1),
    .o_wrap   (w_h_wrap),
    .o_first  (w_h_first),
    .o_sync   (w_h_sync),
    .o_active (w_h_active),
    .o_coord  (w_h_coord)
  );

  // The vertical axis steps once per line, on the horizontal wrap.
  vga_axis_counter #(
    .SYNC   (V_SYNC),
    .BACK   (V_BACK),
    .ACTIVE (V_ACTIVE),
    .FRONT  (V_FRONT)
  ) u_v_cnt (
    .i_clk    (vga_clk),
    .i_rst_n  (rst_n),
    .i_en     (w_h_wrap),
    .o_wrap   (w_v_wrap),
    .o_first  (w_v_first),
    .o_sync   (w_v_sync),
    .o_active (w_v_active),
    .o_coord  (w_v_coord)
  );

  assign w_ready = w_h_active && w_v_active;

  // Stage p1: decode current counters into registered outputs.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync_p1       <= ~H_POL;
      r_vsync_p1       <= ~V_POL;
      r_ready_p1       <= 1'b0;
      r_col_p1         <= '0;
      r_row_p1         <= '0;
      r_frame_start_p1 <= 1'b0;
    end else begin
      r_hsync_p1       <= w_h_sync ? H_POL : ~H_POL;
      r_vsync_p1       <= w_v_sync ? V_POL : ~V_POL;
      r_ready_p1       <= w_ready;
      r_col_p1         <= w_ready ? w_h_coord : '0;
      r_row_p1         <= w_ready ? w_v_coord : '0;
      r_frame_start_p1 <= w_h_first && w_v_first;
    end
  end

`ifdef VGA_SYNC_PIPE_ALIGN_EN
  logic r_hsync_p2, r_vsync_p2;

  // Stage p2: syncs delayed to line up with the colour module's registered RGB.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync_p2 <= ~H_POL;
      r_vsync_p2 <= ~V_POL;
    end else begin
      r_hsync_p2 <= r_hsync_p1;
      r_vsync_p2 <= r_vsync_p1;
    end
  end

  assign HSYNC_Sig = r_hsync_p2;
  assign VSYNC_Sig = r_vsync_p2;
`else
  assign HSYNC_Sig = r_hsync_p1;
  assign VSYNC_Sig = r_vsync_p1;
`endif

  assign Ready_Sig       = r_ready_p1;
  assign Column_Addr_Sig = r_col_p1;
  assign Row_Addr_Sig    = r_row_p1;
  assign Frame_Start_Sig = r_frame_start_p1;

  // The end-of-frame wrap is not needed downstream; frame start comes from the counters.
  logic w_unused;
  assign w_unused = w_v_wrap;

endmodule

// File: tb/tb_vga_sync_gen_module.sv
// Self-checking bench for vga_sync_gen_module on a reduced timing so several
// frames and random resets fit in a short run; reference is cycle-index arithmetic.
module tb_vga_sync_gen_module;

  localparam int HS = 5, HB = 3, HA = 10, HF = 4;
  localparam int VS = 2, VB = 2, VA = 6,  VF = 1;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int FRAME = HT * VT;
  localparam bit HP = 1'b1;
  localparam bit VP = 1'b0;

  logic        vga_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic        HSYNC_Sig, VSYNC_Sig, Ready_Sig, Frame_Start_Sig;
  logic [11:0] Column_Addr_Sig, Row_Addr_Sig;

  always #5 vga_clk = ~vga_clk;

  vga_sync_gen_module #(
    .H_SYNC   (HS), .H_BACK (HB), .H_ACTIVE (HA), .H_FRONT (HF),
    .V_SYNC   (VS), .V_BACK (VB), .V_ACTIVE (VA), .V_FRONT (VF),
    .H_POL    (HP), .V_POL  (VP)
  ) dut (
    .vga_clk         (vga_clk),
    .rst_n           (rst_n),
    .HSYNC_Sig       (HSYNC_Sig),
    .VSYNC_Sig       (VSYNC_Sig),
    .Ready_Sig       (Ready_Sig),
    .Column_Addr_Sig (Column_Addr_Sig),
    .Row_Addr_Sig    (Row_Addr_Sig),
    .Frame_Start_Sig (Frame_Start_Sig)
  );

  typedef struct {
    bit hs;
    bit vs;
    bit rdy;
    bit fs;
    int col;
    int row;
  } exp_t;

  int checks   = 0;
  int failures = 0;
  int n        = 0;   // clock edges seen with reset released
  int g        = 0;   // all clock edges
  int last_fs  = -1;
  int rdy_cnt  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (edge %0d)", tag, got, exp, g);
    end
  endtask

  // Expected outputs for pixel index t since reset release; t<0 means reset state.
  function automatic exp_t model(input int t);
    exp_t e;
    int h, v;
    e.hs = ~HP; e.vs = ~VP; e.rdy = 1'b0; e.fs = 1'b0; e.col = 0; e.row = 0;
    if (t >= 0) begin
      h = t % HT;
      v = (t / HT) % VT;
      e.hs  = (h < HS) ? HP : ~HP;
      e.vs  = (v < VS) ? VP : ~VP;
      e.rdy = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
      e.fs  = (h == 0) && (v == 0);
      e.col = e.rdy ? h - (HS + HB) : 0;
      e.row = e.rdy ? v - (VS + VB) : 0;
    end
    return e;
  endfunction

  task automatic check_all(input string ctx);
    exp_t e, s;
    e = model(n - 1);
`ifdef VGA_SYNC_PIPE_ALIGN_EN
    s = model(n - 2);
`else
    s = e;
`endif
    chk({ctx, "_hsync"}, 32'(HSYNC_Sig), 32'(s.hs));
    chk({ctx, "_vsync"}, 32'(VSYNC_Sig), 32'(s.vs));
    chk({ctx, "_ready"}, 32'(Ready_Sig), 32'(e.rdy));
    chk({ctx, "_col"},   32'(Column_Addr_Sig), e.col);
    chk({ctx, "_row"},   32'(Row_Addr_Sig), e.row);
    chk({ctx, "_fstart"}, 32'(Frame_Start_Sig), 32'(e.fs));
  endtask

  task automatic step();
    @(posedge vga_clk);
    if (rst_n) n++;
    g++;
    #2;
    check_all("cyc");
    if (Ready_Sig === 1'b1) rdy_cnt++;
    if (Frame_Start_Sig === 1'b1) begin
      if (last_fs >= 0) chk("fstart_gap", g - last_fs, FRAME);
      last_fs = g;
    end
  endtask

  // Called 2 time units after an edge: asserts reset mid-cycle, checks the
  // asynchronous effect, holds, then releases between edges.
  task automatic do_reset(input int hold);
    #2;
    rst_n   = 1'b0;
    n       = 0;
    last_fs = -1;
    #1;
    check_all("async_rst");
    repeat (hold) step();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (3) step();
    #2;
    rst_n = 1'b1;

    rdy_cnt = 0;
    repeat (3 * FRAME) step();
    chk("ready_per_3frames", rdy_cnt, 3 * HA * VA);

    do_reset(2);

    // Directed mid-frame reset inside the visible area (v=6, h=12).
    while (n < 6 * HT + 12) step();
    do_reset(1);
    rdy_cnt = 0;
    repeat (FRAME) step();
    chk("ready_after_reset", rdy_cnt, HA * VA);

    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(1, 2 * FRAME)) step();
      do_reset($urandom_range(1, 3));
    end
    repeat (FRAME + 5) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
